// File: rtl/dpc_ip_pkg.sv
// dpc_ip_pkg: shared state encoding, bracket codes and BCD digit arithmetic
package dpc_ip_pkg;
  typedef enum logic [2:0] {PRIME, IDLE, FETCH, SCAN_FETCH, DONE} state_e;
  localparam int BCD_W = 4;
  localparam logic [3:0] DEF_OPEN_CODE = 4'hE;
  localparam logic [3:0] DEF_CLOSE_CODE = 4'hF;
  // Both return {carry/borrow out, digit}; chaining them digit by digit ripples the carry.
  function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] d, input logic ci);
    return !ci ? {1'b0, d} : (d >= 4'd9) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
  endfunction
  function automatic logic [BCD_W:0] bcd_dec(input logic [BCD_W-1:0] d, input logic bi);
    return !bi ? {1'b0, d} : (d == 4'd0) ? {1'b1, 4'd9} : {1'b0, d - 4'd1};
  endfunction
endpackage

// File: rtl/loop_return_stack.sv
// loop_return_stack: circular return-address stack that overwrites its oldest entry when full
module loop_return_stack #(
  parameter int DEPTH = 8,
  parameter int AW = 24,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  output logic [AW-1:0] top,
  output logic [PW:0]   level,
  output logic          overflow
);
  localparam logic [PW:0] FULL = DEPTH[PW:0];
  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full;
  assign full = level_q == FULL;
  assign top = mem_q[ptr_q - 1'b1];
  assign level = level_q;
  assign overflow = ovf_q;
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    level_d = level_q;
    ovf_d = ovf_q;
    if (push) begin
      mem_d[ptr_q] = push_addr;
      ptr_d = ptr_q + 1'b1;
      level_d = full ? level_q : level_q + 1'b1;
      ovf_d = ovf_q | full;
    end else if (pop && level_q != '0) begin
      ptr_d = ptr_q - 1'b1;
      level_d = level_q - 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/ip_loop_stack_line.sv
// ip_loop_stack_line: BCD instruction pointer with loop-return stack and bracket-scan fallback
module ip_loop_stack_line
  import dpc_ip_pkg::*;
#(
  parameter int IP_DIGITS = 6,
  parameter int LOOP_DIGITS = 3,
  parameter int DIGIT_WIDTH = 4,
  parameter int INSN_WIDTH = 4,
  parameter int STACK_DEPTH = 8,
  parameter logic [INSN_WIDTH-1:0] OPEN_CODE = DEF_OPEN_CODE,
  parameter logic [INSN_WIDTH-1:0] CLOSE_CODE = DEF_CLOSE_CODE,
  localparam int AW = IP_DIGITS * DIGIT_WIDTH,
  localparam int LW = LOOP_DIGITS * DIGIT_WIDTH,
  localparam int SW = $clog2(STACK_DEPTH) + 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Request,
  output logic                  Ready,
  input  logic                  dataIsZeroed,
  output logic                  MemReq,
  output logic [AW-1:0]         MemAddr,
  input  logic [INSN_WIDTH-1:0] MemData,
  input  logic                  MemValid,
  output logic [AW-1:0]         Address,
  output logic [LW-1:0]         LoopCount,
  output logic [INSN_WIDTH-1:0] Insn,
  output logic [SW-1:0]         StackLevel,
  output logic                  StackOverflow
);
  localparam logic [LW-1:0] LC_ONE = {{(LW-1){1'b0}}, 1'b1};
  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d, addr_inc, addr_dec, stk_top;
  logic [INSN_WIDTH-1:0]   insn_q, insn_d;
  logic [LW-1:0]           lc_q, lc_d, lc_inc, lc_dec, lc_sat;
  logic                    dir_q, dir_d;
  logic                    pend_q, pend_d;
  logic                    mem_req_q, mem_req_d;
  logic                    push, pop, rd_ok, is_open, is_close, toward, against, stk_empty;
  assign Ready = ~Request & (state_q == IDLE);
  assign MemReq = mem_req_q;
  assign MemAddr = addr_q;
  assign Address = addr_q;
  assign LoopCount = lc_q;
  assign Insn = insn_q;
  // Data is only accepted once the strobe has retired, so stale returns after a reset are dropped.
  assign rd_ok = pend_q & ~mem_req_q & MemValid;
  assign is_open = insn_q == OPEN_CODE;
  assign is_close = insn_q == CLOSE_CODE;
  assign toward = MemData == (dir_q ? CLOSE_CODE : OPEN_CODE);
  assign against = MemData == (dir_q ? OPEN_CODE : CLOSE_CODE);
  assign stk_empty = StackLevel == '0;
  always_comb begin
    logic ci, bi, cl, bl;
    ci = 1'b1;
    bi = 1'b1;
    cl = 1'b1;
    bl = 1'b1;
    addr_inc = '0;
    addr_dec = '0;
    lc_inc = '0;
    lc_dec = '0;
    for (int i = 0; i < IP_DIGITS; i++) begin
      {ci, addr_inc[i*DIGIT_WIDTH +: DIGIT_WIDTH]} = bcd_inc(addr_q[i*DIGIT_WIDTH +: DIGIT_WIDTH], ci);
      {bi, addr_dec[i*DIGIT_WIDTH +: DIGIT_WIDTH]} = bcd_dec(addr_q[i*DIGIT_WIDTH +: DIGIT_WIDTH], bi);
    end
    for (int i = 0; i < LOOP_DIGITS; i++) begin
      {cl, lc_inc[i*DIGIT_WIDTH +: DIGIT_WIDTH]} = bcd_inc(lc_q[i*DIGIT_WIDTH +: DIGIT_WIDTH], cl);
      {bl, lc_dec[i*DIGIT_WIDTH +: DIGIT_WIDTH]} = bcd_dec(lc_q[i*DIGIT_WIDTH +: DIGIT_WIDTH], bl);
    end
    lc_sat = cl ? lc_q : lc_inc;
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    insn_d = insn_q;
    lc_d = lc_q;
    dir_d = dir_q;
    pend_d = pend_q;
    mem_req_d = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    case (state_q)
      PRIME: begin
        if (!pend_q) begin
          mem_req_d = 1'b1;
          pend_d = 1'b1;
        end else if (rd_ok) begin
          insn_d = MemData;
          pend_d = 1'b0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (Request) begin
          mem_req_d = 1'b1;
          pend_d = 1'b1;
          if (is_close && !dataIsZeroed && !stk_empty) begin
            addr_d = stk_top;
            pop = 1'b1;
            state_d = FETCH;
          end else if (is_close && !dataIsZeroed) begin
            lc_d = LC_ONE;
            dir_d = 1'b1;
            addr_d = addr_dec;
            state_d = SCAN_FETCH;
          end else if (is_open && dataIsZeroed) begin
            lc_d = LC_ONE;
            dir_d = 1'b0;
            addr_d = addr_inc;
            state_d = SCAN_FETCH;
          end else begin
            push = is_open;
            pop = is_close;
            addr_d = addr_inc;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (rd_ok) begin
          insn_d = MemData;
          pend_d = 1'b0;
          state_d = DONE;
        end
      end
      SCAN_FETCH: begin
        if (rd_ok) begin
          lc_d = toward ? lc_sat : against ? lc_dec : lc_q;
          if (against && lc_dec == '0) begin
            insn_d = MemData;
            pend_d = 1'b0;
            state_d = DONE;
          end else begin
            addr_d = dir_q ? addr_dec : addr_inc;
            mem_req_d = 1'b1;
          end
        end
      end
      DONE: state_d = Request ? DONE : IDLE;
      default: state_d = PRIME;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= PRIME;
      addr_q <= '0;
      insn_q <= '0;
      lc_q <= '0;
      dir_q <= 1'b0;
      pend_q <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      insn_q <= insn_d;
      lc_q <= lc_d;
      dir_q <= dir_d;
      pend_q <= pend_d;
      mem_req_q <= mem_req_d;
    end
  end
  loop_return_stack #(.DEPTH(STACK_DEPTH), .AW(AW)) u_stack (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .push(push),
    .pop(pop),
    .push_addr(addr_q),
    .top(stk_top),
    .level(StackLevel),
    .overflow(StackOverflow)
  );
endmodule
